// File: rtl/gate_hero_pkg.sv
// Shared constants, lane colours and sequencer states for the note display.
// Exports: NOTE_* geometry, SCREEN_* size, colour constants, state_t, lane_colour().
package gate_hero_pkg;

    localparam int NOTE_W      = 15;
    localparam int NOTE_H      = 7;
    localparam int NOTE_CYCLES = NOTE_W * NOTE_H;
    localparam int SCREEN_W    = 160;
    localparam int SCREEN_H    = 120;

    localparam logic [2:0] COL_ERASE = 3'b000;
    localparam logic [2:0] COL_LANE0 = 3'b010;
    localparam logic [2:0] COL_LANE1 = 3'b100;
    localparam logic [2:0] COL_LANE2 = 3'b110;
    localparam logic [2:0] COL_LANE3 = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_LANE,
        ST_ERASE,
        ST_DRAW,
        ST_DONE
    } state_t;

    function automatic logic [2:0] lane_colour(input logic [1:0] lane);
        logic [2:0] c;
        unique case (lane)
            2'd0:    c = COL_LANE0;
            2'd1:    c = COL_LANE1;
            2'd2:    c = COL_LANE2;
            default: c = COL_LANE3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lane_slot.sv
// One lane's note slot: active/visible/y plus pending spawn and hit strobes.
// Ports: spawn/hit strobes, eval_en/step_en updates, y, eval and step results.
module lane_slot
    import gate_hero_pkg::*;
#(
    parameter int SPEED  = 1,
    parameter int Y_MAX  = 113,
    parameter int HIT_LO = 100,
    parameter int HIT_HI = 113
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spawn,
    input  logic       hit,
    input  logic       eval_en,
    input  logic       step_en,
    output logic [6:0] y,
    output logic       hit_ok,
    output logic       hit_bad,
    output logic       step_erase,
    output logic       step_draw,
    output logic       step_miss,
    output logic [6:0] y_new
);

    logic       active;
    logic       visible;
    logic       spawn_p;
    logic       hit_p;
    logic       in_win;
    logic       spawn_ok;
    logic [7:0] y_next;

    always_comb begin
        in_win   = (y >= 7'(HIT_LO)) && (y <= 7'(HIT_HI));
        hit_ok   = hit_p && active && visible && in_win;
        hit_bad  = hit_p && !hit_ok;
        // Old visible blocks a spawn, so a lane freed by a hit waits a frame.
        spawn_ok = spawn_p && !active && !visible;
        y_next   = {1'b0, y};
        if (active && visible) begin
            y_next = {1'b0, y} + 8'(SPEED);
        end
        step_miss  = active && (y_next > 8'(Y_MAX));
        step_draw  = active && !step_miss;
        step_erase = visible;
        y_new      = y_next[6:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            visible <= 1'b0;
            y       <= '0;
            spawn_p <= 1'b0;
            hit_p   <= 1'b0;
        end else begin
            // A strobe landing on the consuming cycle stays for next frame.
            if (eval_en) begin
                hit_p   <= hit;
                spawn_p <= spawn_ok ? spawn : (spawn_p | spawn);
                if (hit_ok) begin
                    active <= 1'b0;
                end else if (spawn_ok) begin
                    active <= 1'b1;
                    y      <= '0;
                end
            end else begin
                hit_p   <= hit_p | hit;
                spawn_p <= spawn_p | spawn;
            end
            if (step_en) begin
                if (step_miss) begin
                    active  <= 1'b0;
                    visible <= 1'b0;
                end else if (step_draw) begin
                    y       <= y_new;
                    visible <= 1'b1;
                end else begin
                    visible <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Per-frame note animator: evaluates hits/spawns, then erases and redraws
// each lane's note through the 15x7 rasteriser.
// Ports: clk, reset, frame_tick, spawn/hit strobes in; x/y/c base, plot,
//        busy, hit_ok/hit_bad/miss/overrun pulses out (all registered).
module note_sequencer
    import gate_hero_pkg::*;
#(
    parameter int N_LANES    = 4,
    parameter int LANE_X0    = 40,
    parameter int LANE_PITCH = 20,
    parameter int SPEED      = 1,
    parameter int Y_MAX      = 113,
    parameter int HIT_LO     = 100,
    parameter int HIT_HI     = 113
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [N_LANES-1:0] spawn,
    input  logic [N_LANES-1:0] hit,
    output logic [7:0]         x_out,
    output logic [6:0]         y_out,
    output logic [2:0]         c_out,
    output logic               plot,
    output logic               busy,
    output logic [N_LANES-1:0] hit_ok,
    output logic [N_LANES-1:0] hit_bad,
    output logic [N_LANES-1:0] miss,
    output logic               overrun
);

    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    state_t       state;
    logic [LW-1:0] lane;
    logic [6:0]   cnt;
    logic [6:0]   draw_y;
    logic         draw_en;

    logic               eval_en;
    logic [N_LANES-1:0] step_en;
    logic [N_LANES-1:0] s_hit_ok;
    logic [N_LANES-1:0] s_hit_bad;
    logic [N_LANES-1:0] s_erase;
    logic [N_LANES-1:0] s_draw;
    logic [N_LANES-1:0] s_miss;
    logic [6:0]         s_y     [N_LANES];
    logic [6:0]         s_y_new [N_LANES];

    logic       last_lane;
    logic       seg_end;
    logic [7:0] lane_x;
    logic [2:0] lane_c;

    assign eval_en = (state == ST_EVAL);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        assign step_en[i] = (state == ST_LANE) && (lane == LW'(i));
        lane_slot #(
            .SPEED  (SPEED),
            .Y_MAX  (Y_MAX),
            .HIT_LO (HIT_LO),
            .HIT_HI (HIT_HI)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .spawn      (spawn[i]),
            .hit        (hit[i]),
            .eval_en    (eval_en),
            .step_en    (step_en[i]),
            .y          (s_y[i]),
            .hit_ok     (s_hit_ok[i]),
            .hit_bad    (s_hit_bad[i]),
            .step_erase (s_erase[i]),
            .step_draw  (s_draw[i]),
            .step_miss  (s_miss[i]),
            .y_new      (s_y_new[i])
        );
    end

    always_comb begin
        last_lane = (lane == LW'(N_LANES - 1));
        seg_end   = (cnt == 7'(NOTE_CYCLES - 1));
        lane_x    = 8'(LANE_X0 + LANE_PITCH * int'(lane));
        lane_c    = lane_colour(2'(lane));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            lane    <= '0;
            cnt     <= '0;
            draw_y  <= '0;
            draw_en <= 1'b0;
            x_out   <= '0;
            y_out   <= '0;
            c_out   <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            hit_ok  <= '0;
            hit_bad <= '0;
            miss    <= '0;
            overrun <= 1'b0;
        end else begin
            hit_ok  <= s_hit_ok & {N_LANES{eval_en}};
            hit_bad <= s_hit_bad & {N_LANES{eval_en}};
            miss    <= step_en & s_miss;
            overrun <= frame_tick && (state != ST_IDLE);
            unique case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state <= ST_EVAL;
                        busy  <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    lane  <= '0;
                    state <= ST_LANE;
                end
                ST_LANE: begin
                    draw_y  <= s_y_new[lane];
                    draw_en <= s_draw[lane];
                    cnt     <= '0;
                    x_out   <= lane_x;
                    if (s_erase[lane]) begin
                        state <= ST_ERASE;
                        plot  <= 1'b1;
                        y_out <= s_y[lane];
                        c_out <= COL_ERASE;
                    end else if (s_draw[lane]) begin
                        state <= ST_DRAW;
                        plot  <= 1'b1;
                        y_out <= s_y_new[lane];
                        c_out <= lane_c;
                    end else if (last_lane) begin
                        state <= ST_DONE;
                    end else begin
                        lane <= lane + 1'b1;
                    end
                end
                ST_ERASE: begin
                    cnt <= cnt + 7'd1;
                    if (seg_end) begin
                        cnt <= '0;
                        if (draw_en) begin
                            state <= ST_DRAW;
                            y_out <= draw_y;
                            c_out <= lane_c;
                        end else begin
                            plot <= 1'b0;
                            if (last_lane) begin
                                state <= ST_DONE;
                            end else begin
                                lane  <= lane + 1'b1;
                                state <= ST_LANE;
                            end
                        end
                    end
                end
                ST_DRAW: begin
                    cnt <= cnt + 7'd1;
                    if (seg_end) begin
                        cnt  <= '0;
                        plot <= 1'b0;
                        if (last_lane) begin
                            state <= ST_DONE;
                        end else begin
                            lane  <= lane + 1'b1;
                            state <= ST_LANE;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: records plotted rectangles and pulses,
// walks notes through spawn, hit, miss, overrun and reset scenarios.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [3:0] spawn;
    logic [3:0] hit;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] c_out;
    logic       plot;
    logic       busy;
    logic [3:0] hit_ok;
    logic [3:0] hit_bad;
    logic [3:0] miss;
    logic       overrun;

    note_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .spawn      (spawn),
        .hit        (hit),
        .x_out      (x_out),
        .y_out      (y_out),
        .c_out      (c_out),
        .plot       (plot),
        .busy       (busy),
        .hit_ok     (hit_ok),
        .hit_bad    (hit_bad),
        .miss       (miss),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frame_no = 0;
    int tick_cyc = 0;

    int sx[$];
    int sy[$];
    int sc[$];
    int sl[$];
    bit seg_open = 0;
    int cx, cy, cc, cl;

    int busy_cnt, busy_first;
    logic [3:0] ok_acc, bad_acc, miss_acc;
    int ok_n, bad_n, miss_n, ov_n;
    int ok_cyc, miss_cyc, ov_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (plot) begin
            if (seg_open && int'(x_out) == cx && int'(y_out) == cy
                && int'(c_out) == cc) begin
                cl++;
            end else begin
                if (seg_open) begin
                    sx.push_back(cx); sy.push_back(cy);
                    sc.push_back(cc); sl.push_back(cl);
                end
                seg_open = 1;
                cx = int'(x_out); cy = int'(y_out);
                cc = int'(c_out); cl = 1;
            end
        end else if (seg_open) begin
            sx.push_back(cx); sy.push_back(cy);
            sc.push_back(cc); sl.push_back(cl);
            seg_open = 0;
        end
        if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
        end
        if (hit_ok != 0) begin
            ok_acc |= hit_ok; ok_n++; ok_cyc = cyc;
        end
        if (hit_bad != 0) begin
            bad_acc |= hit_bad; bad_n++;
        end
        if (miss != 0) begin
            miss_acc |= miss; miss_n++; miss_cyc = cyc;
        end
        if (overrun) begin
            ov_n++; ov_cyc = cyc;
        end
    end

    task automatic clear_rec();
        sx.delete(); sy.delete(); sc.delete(); sl.delete();
        busy_cnt = 0; busy_first = -1;
        ok_acc = 0; bad_acc = 0; miss_acc = 0;
        ok_n = 0; bad_n = 0; miss_n = 0; ov_n = 0;
        ok_cyc = -1; miss_cyc = -1; ov_cyc = -1;
    endtask

    function automatic int nth_seg(int x, int k);
        int n = 0;
        for (int i = 0; i < sx.size(); i++) begin
            if (sx[i] == x) begin
                if (n == k) return i;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic int count_seg(int x);
        int n = 0;
        for (int i = 0; i < sx.size(); i++)
            if (sx[i] == x) n++;
        return n;
    endfunction

    task automatic strobe(input logic [3:0] sp, input logic [3:0] ht);
        @(posedge clk); #1;
        spawn = sp; hit = ht;
        @(posedge clk); #1;
        spawn = 0; hit = 0;
    endtask

    // One frame; ov_at > 0 injects a second tick that many cycles later.
    task automatic run_frame(input int ov_at);
        int n;
        clear_rec();
        @(posedge clk); #1;
        frame_tick = 1; tick_cyc = cyc;
        @(posedge clk); #1;
        frame_tick = 0;
        if (ov_at > 0) begin
            repeat (ov_at - 1) @(posedge clk);
            #1 frame_tick = 1;
            @(posedge clk); #1;
            frame_tick = 0;
        end
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL frame_timeout frame=%0d busy stuck", frame_no + 1);
        end
        @(negedge clk);
        frame_no++;
    endtask

    task automatic advance_to(input int f);
        while (frame_no < f) run_frame(0);
    endtask

    task automatic test_reset();
        reset = 1; frame_tick = 0; spawn = 0; hit = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl plot=%b busy=%b want 0 0", plot, busy);
        end
        total++;
        if (x_out !== 8'd0 || y_out !== 7'd0 || c_out !== 3'd0) begin
            bad++;
            $display("FAIL reset_base got %0d,%0d,%0d want 0,0,0",
                     x_out, y_out, c_out);
        end
        total++;
        if (hit_ok !== 0 || hit_bad !== 0 || miss !== 0 || overrun !== 0) begin
            bad++;
            $display("FAIL reset_pulses ok=%b bad=%b miss=%b ov=%b want 0",
                     hit_ok, hit_bad, miss, overrun);
        end
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic test_spawn_draw();
        int j;
        strobe(4'b0100, 4'b0000);
        run_frame(0);
        total++;
        if (sx.size() !== 1) begin
            bad++; $display("FAIL f1_count got %0d want 1", sx.size());
        end
        j = nth_seg(80, 0);
        total++;
        if (j < 0 || sy[j] !== 0 || sc[j] !== 6 || sl[j] !== 105) begin
            bad++;
            $display("FAIL f1_draw got idx=%0d y=%0d c=%0d len=%0d want y=0 c=6 len=105",
                     j, sy[j], sc[j], sl[j]);
        end
        total++;
        if (busy_first - tick_cyc !== 1 || busy_cnt !== 111) begin
            bad++;
            $display("FAIL f1_busy got start=+%0d len=%0d want +1 111",
                     busy_first - tick_cyc, busy_cnt);
        end
        run_frame(0);
        j = nth_seg(80, 0);
        total++;
        if (j < 0 || sy[j] !== 0 || sc[j] !== 0 || sl[j] !== 105) begin
            bad++;
            $display("FAIL f2_erase got y=%0d c=%0d len=%0d want 0 0 105",
                     sy[j], sc[j], sl[j]);
        end
        j = nth_seg(80, 1);
        total++;
        if (j < 0 || sy[j] !== 1 || sc[j] !== 6 || sl[j] !== 105) begin
            bad++;
            $display("FAIL f2_draw got y=%0d c=%0d len=%0d want 1 6 105",
                     sy[j], sc[j], sl[j]);
        end
        total++;
        if (busy_cnt !== 216) begin
            bad++; $display("FAIL f2_busy got %0d want 216", busy_cnt);
        end
        run_frame(0);
        j = nth_seg(80, 1);
        total++;
        if (j < 0 || sy[j] !== 2 || sc[j] !== 6) begin
            bad++; $display("FAIL f3_draw got y=%0d c=%0d want 2 6", sy[j], sc[j]);
        end
    endtask

    task automatic test_two_lanes();
        int j;
        advance_to(8);
        strobe(4'b1000, 4'b0000);
        run_frame(0);
        total++;
        if (sx.size() !== 3) begin
            bad++; $display("FAIL f9_count got %0d want 3", sx.size());
        end
        j = nth_seg(80, 1);
        total++;
        if (j < 0 || sy[j] !== 8) begin
            bad++; $display("FAIL f9_lane2 got y=%0d want 8", sy[j]);
        end
        j = nth_seg(100, 0);
        total++;
        if (j !== 2 || sy[j] !== 0 || sc[j] !== 1 || sl[j] !== 105) begin
            bad++;
            $display("FAIL f9_lane3 got idx=%0d y=%0d c=%0d len=%0d want 2 0 1 105",
                     j, sy[j], sc[j], sl[j]);
        end
    endtask

    task automatic test_overrun();
        int j;
        run_frame(300);
        total++;
        if (ov_n !== 1 || ov_cyc - tick_cyc !== 301) begin
            bad++;
            $display("FAIL overrun_pulse got n=%0d at=+%0d want 1 +301",
                     ov_n, ov_cyc - tick_cyc);
        end
        j = nth_seg(100, 1);
        total++;
        if (sx.size() !== 4 || busy_cnt !== 426 || j < 0 || sy[j] !== 1) begin
            bad++;
            $display("FAIL overrun_frame got segs=%0d busy=%0d y=%0d want 4 426 1",
                     sx.size(), busy_cnt, sy[j]);
        end
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL overrun_extra got busy=%b want 0", busy);
        end
    endtask

    task automatic test_hit_ok();
        int j;
        advance_to(56);
        strobe(4'b0010, 4'b0000);
        advance_to(106);
        strobe(4'b0100, 4'b0100);
        run_frame(0);
        total++;
        if (ok_acc !== 4'b0100 || ok_n !== 1 || ok_cyc - tick_cyc !== 2) begin
            bad++;
            $display("FAIL hit_ok got %b n=%0d at=+%0d want 0100 1 +2",
                     ok_acc, ok_n, ok_cyc - tick_cyc);
        end
        total++;
        if (bad_acc !== 4'b0000) begin
            bad++; $display("FAIL hit_ok_nobad got %b want 0000", bad_acc);
        end
        j = nth_seg(80, 0);
        total++;
        if (count_seg(80) !== 1 || j < 0 || sy[j] !== 105 || sc[j] !== 0) begin
            bad++;
            $display("FAIL hit_ok_erase got n=%0d y=%0d c=%0d want 1 105 0",
                     count_seg(80), sy[j], sc[j]);
        end
    endtask

    task automatic test_hit_bad();
        int j;
        strobe(4'b0000, 4'b0010);
        run_frame(0);
        total++;
        if (bad_acc !== 4'b0010 || ok_acc !== 4'b0000) begin
            bad++;
            $display("FAIL hit_bad got bad=%b ok=%b want 0010 0000", bad_acc, ok_acc);
        end
        j = nth_seg(60, 1);
        total++;
        if (j < 0 || sy[j] !== 51 || sc[j] !== 4 || sy[j-1] !== 50) begin
            bad++;
            $display("FAIL hit_bad_move got y=%0d c=%0d want 51 4", sy[j], sc[j]);
        end
        j = nth_seg(80, 0);
        total++;
        if (count_seg(80) !== 1 || j < 0 || sy[j] !== 0 || sc[j] !== 6) begin
            bad++;
            $display("FAIL deferred_spawn got n=%0d y=%0d c=%0d want 1 0 6",
                     count_seg(80), sy[j], sc[j]);
        end
    endtask

    task automatic test_miss();
        int j;
        advance_to(121);
        run_frame(0);
        j = nth_seg(100, 1);
        total++;
        if (j < 0 || sy[j] !== 113 || miss_acc !== 0) begin
            bad++;
            $display("FAIL edge_draw got y=%0d miss=%b want 113 0000", sy[j], miss_acc);
        end
        run_frame(0);
        j = nth_seg(100, 0);
        total++;
        if (count_seg(100) !== 1 || j < 0 || sy[j] !== 113 || sc[j] !== 0) begin
            bad++;
            $display("FAIL miss_erase got n=%0d y=%0d c=%0d want 1 113 0",
                     count_seg(100), sy[j], sc[j]);
        end
        total++;
        if (miss_acc !== 4'b1000 || miss_n !== 1 || miss_cyc - tick_cyc !== 426) begin
            bad++;
            $display("FAIL miss_pulse got %b n=%0d at=+%0d want 1000 1 +426",
                     miss_acc, miss_n, miss_cyc - tick_cyc);
        end
        run_frame(0);
        total++;
        if (count_seg(100) !== 0) begin
            bad++; $display("FAIL miss_gone got %0d want 0", count_seg(100));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_rec();
        @(posedge clk); #1 frame_tick = 1;
        @(posedge clk); #1 frame_tick = 0;
        n = 0;
        while (!(plot && c_out != 0) && n < 1000) begin @(negedge clk); n++; end
        total++;
        if (n >= 1000) begin
            bad++; $display("FAIL mid_wait got no draw want draw");
        end
        @(posedge clk); #1 reset = 1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (plot !== 0 || busy !== 0 || x_out !== 0 || y_out !== 0 || c_out !== 0) begin
            bad++;
            $display("FAIL mid_reset got plot=%b busy=%b base=%0d,%0d,%0d want 0",
                     plot, busy, x_out, y_out, c_out);
        end
        @(posedge clk); #1 reset = 0;
        clear_rec();
        repeat (20) @(negedge clk);
        total++;
        if (sx.size() !== 0 || busy_cnt !== 0 || ok_n + bad_n + miss_n + ov_n !== 0) begin
            bad++;
            $display("FAIL post_reset got segs=%0d busy=%0d pulses=%0d want 0",
                     sx.size(), busy_cnt, ok_n + bad_n + miss_n + ov_n);
        end
        run_frame(0);
        total++;
        if (sx.size() !== 0 || busy_cnt !== 6) begin
            bad++;
            $display("FAIL empty_frame got segs=%0d busy=%0d want 0 6",
                     sx.size(), busy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_spawn_draw();
        test_two_lanes();
        test_overrun();
        test_hit_ok();
        test_hit_bad();
        test_miss();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
